// File: rtl/fp_addsub_seq.sv
// Multi-cycle floating-point adder/subtractor: align, add, normalise one step per clock.
// Truncating rounding; zero-exponent operands are treated as zero.
module fp_addsub_seq #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
) (
  input  logic                         clk,
  input  logic                         n_rst,
  input  logic                         start,
  input  logic                         mode,
  input  logic [1+EXP_W+MAN_W-1:0]     op1,
  input  logic [1+EXP_W+MAN_W-1:0]     op2,
  output logic [1+EXP_W+MAN_W-1:0]     result,
  output logic                         done,
  output logic                         busy,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int unsigned W    = 1 + EXP_W + MAN_W;
  localparam int unsigned MX_W = MAN_W + 3;  // {hidden, man, 2 guard}
  localparam int unsigned AC_W = MAN_W + 4;  // carry + MX_W
  localparam logic [EXP_W-1:0] EXP_ONES = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ALIGN,
    S_ADD,
    S_NORM,
    S_FINISH
  } state_t;

  state_t             state;
  logic               a_sign, b_sign;
  logic [EXP_W-1:0]   a_exp, b_exp;
  logic [MAN_W-1:0]   a_man, b_man;
  logic [MX_W-1:0]    x_mant, y_mant;
  logic               eff_sub;
  logic               inf_in;
  logic [AC_W-1:0]    acc;
  logic [EXP_W-1:0]   exp_r;
  logic               sign_r;

  // Alignment: order operands by magnitude and shift the smaller one
  logic               swap_c;
  logic               big_sign_c;
  logic [EXP_W-1:0]   big_exp_c, sml_exp_c, diff_c;
  logic [MAN_W-1:0]   big_man_c, sml_man_c;
  logic [MX_W-1:0]    big_mant_c, sml_mant_c, sml_shift_c;

  always_comb begin
    swap_c      = {b_exp, b_man} > {a_exp, a_man};
    big_sign_c  = swap_c ? b_sign : a_sign;
    big_exp_c   = swap_c ? b_exp  : a_exp;
    big_man_c   = swap_c ? b_man  : a_man;
    sml_exp_c   = swap_c ? a_exp  : b_exp;
    sml_man_c   = swap_c ? a_man  : b_man;
    big_mant_c  = (big_exp_c == '0) ? '0 : {1'b1, big_man_c, 2'b00};
    sml_mant_c  = (sml_exp_c == '0) ? '0 : {1'b1, sml_man_c, 2'b00};
    diff_c      = big_exp_c - sml_exp_c;
    sml_shift_c = (32'(diff_c) >= MX_W) ? '0 : (sml_mant_c >> diff_c);
  end

  // Normalisation decision for the current NORM cycle
  logic               norm_fin_c;
  logic               norm_ovf_c;
  logic               norm_unf_c;
  logic [W-1:0]       norm_res_c;
  logic [EXP_W-1:0]   exp_inc_c;

  always_comb begin
    norm_fin_c = 1'b1;
    norm_ovf_c = 1'b0;
    norm_unf_c = 1'b0;
    norm_res_c = '0;
    exp_inc_c  = exp_r + EXP_W'(1);
    if (inf_in) begin
      norm_ovf_c = 1'b1;
      norm_res_c = {sign_r, EXP_ONES, MAN_W'(0)};
    end else if (acc[AC_W-1]) begin
      if (exp_inc_c == EXP_ONES) begin
        norm_ovf_c = 1'b1;
        norm_res_c = {sign_r, EXP_ONES, MAN_W'(0)};
      end else begin
        norm_res_c = {sign_r, exp_inc_c, acc[AC_W-2:3]};
      end
    end else if (acc == '0) begin
      norm_res_c = '0;
    end else if (acc[AC_W-2]) begin
      norm_res_c = {sign_r, exp_r, acc[AC_W-3:2]};
    end else if (exp_r <= EXP_W'(1)) begin
      norm_unf_c = 1'b1;
      norm_res_c = {sign_r, EXP_W'(0), MAN_W'(0)};
    end else begin
      norm_fin_c = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= S_IDLE;
      result    <= '0;
      done      <= 1'b0;
      busy      <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      a_sign    <= 1'b0;
      a_exp     <= '0;
      a_man     <= '0;
      b_sign    <= 1'b0;
      b_exp     <= '0;
      b_man     <= '0;
      x_mant    <= '0;
      y_mant    <= '0;
      eff_sub   <= 1'b0;
      inf_in    <= 1'b0;
      acc       <= '0;
      exp_r     <= '0;
      sign_r    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            {a_sign, a_exp, a_man} <= op1;
            {b_sign, b_exp, b_man} <= {op2[W-1] ^ mode, op2[W-2:0]};
            busy  <= 1'b1;
            state <= S_ALIGN;
          end
        end
        S_ALIGN: begin
          x_mant  <= big_mant_c;
          y_mant  <= sml_shift_c;
          exp_r   <= big_exp_c;
          sign_r  <= big_sign_c;
          eff_sub <= a_sign ^ b_sign;
          inf_in  <= (a_exp == EXP_ONES) || (b_exp == EXP_ONES);
          state   <= S_ADD;
        end
        S_ADD: begin
          acc   <= eff_sub ? (AC_W'(x_mant) - AC_W'(y_mant))
                           : (AC_W'(x_mant) + AC_W'(y_mant));
          state <= S_NORM;
        end
        S_NORM: begin
          if (norm_fin_c) begin
            result    <= norm_res_c;
            overflow  <= norm_ovf_c;
            underflow <= norm_unf_c;
            done      <= 1'b1;
            state     <= S_FINISH;
          end else begin
            acc   <= acc << 1;
            exp_r <= exp_r - EXP_W'(1);
          end
        end
        S_FINISH: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_addsub_seq.sv
// Scoreboard bench for fp_addsub_seq: directed operand pairs, latency, flags,
// reset abort and start-while-busy handling.
module tb_fp_addsub_seq;

  localparam int unsigned W = 32;

  logic         clk;
  logic         n_rst;
  logic         start;
  logic         mode;
  logic [W-1:0] op1, op2;
  logic [W-1:0] result;
  logic         done, busy, overflow, underflow;

  typedef struct {
    logic [W-1:0] res;
    logic         ovf;
    logic         unf;
    int           lat;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests;
  int   n_fail;

  fp_addsub_seq #(.EXP_W(8), .MAN_W(23)) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .start     (start),
    .mode      (mode),
    .op1       (op1),
    .op2       (op2),
    .result    (result),
    .done      (done),
    .busy      (busy),
    .overflow  (overflow),
    .underflow (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  // Pulse start for exactly one sampling edge; returns #1 after that edge.
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic m);
    @(negedge clk);
    op1 = a; op2 = b; mode = m; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Wait for done (edges counted from the start-sampling edge) and score it.
  task automatic collect(input string tag, input int edges_so_far);
    int   n;
    bit   seen;
    exp_t e;
    n = edges_so_far;
    seen = 0;
    while (!seen && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (done) seen = 1;
    end
    if (!seen) begin
      check({tag, "_timeout"}, 64'(0), 64'(1));
    end else if (exp_q.size() == 0) begin
      check({tag, "_unexpected_done"}, 64'(1), 64'(0));
    end else begin
      e = exp_q.pop_front();
      check({tag, "_result"}, 64'(result), 64'(e.res));
      check({tag, "_ovf"},    64'(overflow), 64'(e.ovf));
      check({tag, "_unf"},    64'(underflow), 64'(e.unf));
      check({tag, "_latency"}, 64'(n), 64'(e.lat));
      check({tag, "_busy_at_done"}, 64'(busy), 64'(1));
      @(posedge clk); #1;
      check({tag, "_done_pulse"}, 64'(done), 64'(0));
      check({tag, "_busy_after"}, 64'(busy), 64'(0));
      check({tag, "_result_hold"}, 64'(result), 64'(e.res));
    end
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic m, input logic [W-1:0] r, input logic ovf,
                        input logic unf, input int lat);
    exp_t e;
    e.res = r; e.ovf = ovf; e.unf = unf; e.lat = lat;
    exp_q.push_back(e);
    launch(a, b, m);
    check({tag, "_busy_start"}, 64'(busy), 64'(1));
    collect(tag, 0);
  endtask

  initial begin
    int dcount;
    exp_t e;
    n_tests = 0;
    n_fail  = 0;
    n_rst = 1'b0;
    start = 1'b0;
    mode  = 1'b0;
    op1   = '0;
    op2   = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_result", 64'(result), 64'(0));
    check("rst_done",   64'(done), 64'(0));
    check("rst_busy",   64'(busy), 64'(0));
    check("rst_ovf",    64'(overflow), 64'(0));
    check("rst_unf",    64'(underflow), 64'(0));
    @(negedge clk);
    n_rst = 1'b1;

    run_op("add_125_15",  32'h3FA00000, 32'h3FC00000, 1'b0, 32'h40300000, 1'b0, 1'b0, 3);
    run_op("sub_15_125",  32'h3FC00000, 32'h3FA00000, 1'b1, 32'h3E800000, 1'b0, 1'b0, 5);
    run_op("ovf_max",     32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 1'b1, 1'b0, 3);
    run_op("cancel_pi",   32'h40490FDB, 32'h40490FDB, 1'b1, 32'h00000000, 1'b0, 1'b0, 3);
    run_op("diff23",      32'h4B000000, 32'h3F800000, 1'b0, 32'h4B000001, 1'b0, 1'b0, 3);
    run_op("diff25",      32'h4C000000, 32'h3F800000, 1'b0, 32'h4C000000, 1'b0, 1'b0, 3);
    run_op("inf_in",      32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 1'b1, 1'b0, 3);
    run_op("neg_mix",     32'hBFC00000, 32'h3FA00000, 1'b0, 32'hBE800000, 1'b0, 1'b0, 5);
    run_op("unf_min",     32'h00800000, 32'h00C00000, 1'b1, 32'h80000000, 1'b0, 1'b1, 3);
    run_op("plus_zero",   32'h3F800000, 32'h00000000, 1'b0, 32'h3F800000, 1'b0, 1'b0, 3);
    run_op("sub_2_1",     32'h40000000, 32'h3F800000, 1'b1, 32'h3F800000, 1'b0, 1'b0, 4);

    // start while busy must be ignored
    e.res = 32'h40300000; e.ovf = 1'b0; e.unf = 1'b0; e.lat = 3;
    exp_q.push_back(e);
    launch(32'h3FA00000, 32'h3FC00000, 1'b0);
    @(negedge clk);
    op1 = 32'h7F7FFFFF; op2 = 32'h7F7FFFFF; mode = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    collect("busy_ignore", 1);
    dcount = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done) dcount++;
    end
    check("busy_ignore_no_extra_done", 64'(dcount), 64'(0));

    // reset while in NORM aborts with no done
    launch(32'h3FC00000, 32'h3FA00000, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check("abort_busy_before", 64'(busy), 64'(1));
    n_rst = 1'b0;
    #1;
    check("abort_result", 64'(result), 64'(0));
    check("abort_busy",   64'(busy), 64'(0));
    check("abort_done",   64'(done), 64'(0));
    check("abort_flags",  64'({overflow, underflow}), 64'(0));
    @(negedge clk);
    n_rst = 1'b1;
    dcount = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done) dcount++;
    end
    check("abort_no_done", 64'(dcount), 64'(0));

    run_op("after_reset", 32'h3FA00000, 32'h3FC00000, 1'b0, 32'h40300000, 1'b0, 1'b0, 3);
    check("queue_empty", 64'(exp_q.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
